// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - ID-stage decoder with ID/EX register, load-use stall, branch flush and perf counters
// Hazard and flush lines are combinational; everything bound for EX is registered.
module pipelined_control_unit #(
  parameter int REG_AW    = 5,
  parameter int CNT_W     = 16,
  parameter int HAZARD_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  input  logic              branch_taken,
  output logic              stall_o,
  output logic              flush_o,
  output logic              ex_alu_src,
  output logic              ex_mem_to_reg,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic [1:0]        ex_alu_op,
  output logic [1:0]        ex_imm_sel,
  output logic              ex_alu_sub,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_valid,
  output logic              illegal_o,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_NOP   = 7'b0000000;
  localparam logic       HAZ_ON   = (HAZARD_EN != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // ctrl order: {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch}
  logic [5:0]        dec_ctrl;
  logic [1:0]        dec_alu_op;
  logic [1:0]        dec_imm_sel;
  logic              dec_sub;
  logic              dec_illegal;
  logic              rs2_used;
  logic [1:0]        f3_alu_op;
  logic              f3_ok;
  logic              load_use;

  logic [5:0]        ex_ctrl_q, ex_ctrl_d;
  logic [1:0]        ex_alu_op_q, ex_alu_op_d;
  logic [1:0]        ex_imm_sel_q, ex_imm_sel_d;
  logic              ex_alu_sub_q, ex_alu_sub_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              ex_valid_q, ex_valid_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  always_comb begin
    f3_alu_op = 2'b00;
    f3_ok     = 1'b1;
    case (funct3)
      3'b000:  f3_alu_op = 2'b10;
      3'b111:  f3_alu_op = 2'b00;
      3'b110:  f3_alu_op = 2'b01;
      default: f3_ok     = 1'b0;
    endcase
  end

  always_comb begin
    dec_ctrl    = 6'b000000;
    dec_alu_op  = 2'b00;
    dec_imm_sel = 2'b00;
    dec_sub     = 1'b0;
    dec_illegal = 1'b0;
    rs2_used    = 1'b0;
    case (opcode)
      OP_R: begin
        dec_ctrl    = 6'b001000;
        dec_alu_op  = f3_alu_op;
        dec_imm_sel = 2'b11;
        dec_sub     = (funct3 == 3'b000) & funct7_5;
        dec_illegal = ~f3_ok;
        rs2_used    = 1'b1;
      end
      OP_IALU: begin
        dec_ctrl    = 6'b101000;
        dec_alu_op  = f3_alu_op;
        dec_illegal = ~f3_ok;
      end
      OP_LOAD: begin
        dec_ctrl    = 6'b111100;
        dec_alu_op  = 2'b10;
      end
      OP_STORE: begin
        dec_ctrl    = 6'b110010;
        dec_alu_op  = 2'b10;
        dec_imm_sel = 2'b01;
        rs2_used    = 1'b1;
      end
      OP_BR: begin
        dec_ctrl    = 6'b000001;
        dec_alu_op  = 2'b10;
        dec_imm_sel = 2'b10;
        rs2_used    = 1'b1;
      end
      OP_NOP:  dec_illegal = 1'b0;
      default: dec_illegal = 1'b1;
    endcase
  end

  assign load_use = HAZ_ON & id_valid & ex_valid_q & ex_ctrl_q[2] & (ex_rd_q != '0) &
                    ((ex_rd_q == rs1) | (rs2_used & (ex_rd_q == rs2)));

  assign stall_o = load_use & ~branch_taken;
  assign flush_o = branch_taken;

  // Default is a bubble; only a clean, valid, non-hazarded instruction is loaded.
  always_comb begin
    ex_ctrl_d    = 6'b000000;
    ex_alu_op_d  = 2'b00;
    ex_imm_sel_d = 2'b00;
    ex_alu_sub_d = 1'b0;
    ex_rd_d      = '0;
    ex_valid_d   = 1'b0;
    illegal_d    = illegal_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (branch_taken) begin
      if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (load_use) begin
      if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else if (id_valid & dec_illegal) begin
      illegal_d = 1'b1;
    end else if (id_valid) begin
      ex_ctrl_d    = dec_ctrl;
      ex_alu_op_d  = dec_alu_op;
      ex_imm_sel_d = dec_imm_sel;
      ex_alu_sub_d = dec_sub;
      ex_rd_d      = rd;
      ex_valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl_q    <= 6'b000000;
      ex_alu_op_q  <= 2'b00;
      ex_imm_sel_q <= 2'b00;
      ex_alu_sub_q <= 1'b0;
      ex_rd_q      <= '0;
      ex_valid_q   <= 1'b0;
      illegal_q    <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      ex_ctrl_q    <= ex_ctrl_d;
      ex_alu_op_q  <= ex_alu_op_d;
      ex_imm_sel_q <= ex_imm_sel_d;
      ex_alu_sub_q <= ex_alu_sub_d;
      ex_rd_q      <= ex_rd_d;
      ex_valid_q   <= ex_valid_d;
      illegal_q    <= illegal_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign {ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch} = ex_ctrl_q;
  assign ex_alu_op  = ex_alu_op_q;
  assign ex_imm_sel = ex_imm_sel_q;
  assign ex_alu_sub = ex_alu_sub_q;
  assign ex_rd      = ex_rd_q;
  assign ex_valid   = ex_valid_q;
  assign illegal_o  = illegal_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule
